// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Operation codes, FSM states and the hard-wired zero register index.
package muldiv_pkg;

    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_MULHU = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_REMU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_CALC  = 2'b01,
        S_WRITE = 2'b10
    } state_t;

    localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/muldiv_datapath.sv
// Shift-add multiplier / restoring divider datapath, one result bit per step.
// {hi, lo} holds {acc, multiplier} for multiply and {rem, quotient} for divide.
module muldiv_datapath #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic             isDiv,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] accReg;
    logic [WIDTH-1:0] loReg;
    logic [WIDTH-1:0] operand;

    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   remShift;
    logic [WIDTH-1:0] remDiff;
    logic             remFits;

    always_comb begin
        mulSum   = {1'b0, accReg} + (loReg[0] ? {1'b0, operand} : '0);
        remShift = {accReg, loReg[WIDTH-1]};
        remFits  = remShift >= {1'b0, operand};
        // Only taken when remShift >= operand, so the result fits in WIDTH bits.
        remDiff  = remShift[WIDTH-1:0] - operand;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accReg  <= '0;
            loReg   <= '0;
            operand <= '0;
        end else if (load) begin
            accReg  <= '0;
            loReg   <= opA;
            operand <= opB;
        end else if (step) begin
            if (isDiv) begin
                accReg <= remFits ? remDiff : remShift[WIDTH-1:0];
                loReg  <= {loReg[WIDTH-2:0], remFits};
            end else begin
                accReg <= mulSum[WIDTH:1];
                loReg  <= {mulSum[0], loReg[WIDTH-1:1]};
            end
        end
    end

    assign hi = accReg;
    assign lo = loReg;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative unsigned MUL/MULHU/DIVU/REMU unit with a RegisterFile write-back port.
// Holds the control FSM, iteration counter and registered write-back outputs.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [WIDTH-1:0]  opA,
    input  logic [WIDTH-1:0]  opB,
    input  logic [ADDR_W-1:0] dest,
    input  logic              flush,
    output logic              busy,
    output logic              done,
    output logic              RW,
    output logic [ADDR_W-1:0] DA,
    output logic [WIDTH-1:0]  writeData
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t            state;
    logic [CNT_W-1:0]  counter;
    logic [1:0]        opReg;
    logic [ADDR_W-1:0] destReg;
    logic              divZero;

    logic              accept;
    logic              step;
    logic [WIDTH-1:0]  hi;
    logic [WIDTH-1:0]  lo;
    logic [WIDTH-1:0]  result;

    assign accept = (state == S_IDLE) && start && !flush;
    assign step   = (state == S_CALC) && !flush;

    muldiv_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk  (clk),
        .reset(reset),
        .load (accept),
        .step (step),
        .isDiv(opReg[1]),
        .opA  (opA),
        .opB  (opB),
        .hi   (hi),
        .lo   (lo)
    );

    // On divide-by-zero the dividend is still sitting untouched in lo.
    always_comb begin
        result = lo;
        unique case (opReg)
            OP_MUL:   result = lo;
            OP_MULHU: result = hi;
            OP_DIVU:  result = divZero ? '1 : lo;
            OP_REMU:  result = divZero ? lo : hi;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            counter   <= '0;
            opReg     <= OP_MUL;
            destReg   <= '0;
            divZero   <= 1'b0;
            RW        <= 1'b0;
            done      <= 1'b0;
            DA        <= '0;
            writeData <= '0;
        end else begin
            RW   <= 1'b0;
            done <= 1'b0;
            if (flush && (state != S_IDLE)) begin
                state <= S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (accept) begin
                            opReg   <= op;
                            destReg <= dest;
                            divZero <= op[1] && (opB == '0);
                            if (op[1] && (opB == '0)) begin
                                state <= S_WRITE;
                            end else begin
                                counter <= CNT_W'(WIDTH - 1);
                                state   <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        if (counter == '0) begin
                            state <= S_WRITE;
                        end else begin
                            counter <= counter - 1'b1;
                        end
                    end
                    S_WRITE: begin
                        RW        <= (destReg != ADDR_W'(ZERO_REG));
                        done      <= 1'b1;
                        DA        <= destReg;
                        writeData <= result;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // The completion pulse is shown after WRITE, so busy covers that cycle too.
    assign busy = (state != S_IDLE) || done;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed plan cases plus randomized operations
// checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [4:0]  dest;
    logic        flush;
    logic        busy;
    logic        done;
    logic        RW;
    logic [4:0]  DA;
    logic [31:0] writeData;

    typedef struct {
        logic        rw;
        logic [4:0]  da;
        logic [31:0] data;
        int          startCyc;
        int          doneCyc;
    } exp_t;

    exp_t sb[$];
    exp_t monE;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    muldiv_unit #(
        .WIDTH (32),
        .ADDR_W(5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .opA      (opA),
        .opB      (opB),
        .dest     (dest),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .RW       (RW),
        .DA       (DA),
        .writeData(writeData)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            OP_MUL:   return p[31:0];
            OP_MULHU: return p[63:32];
            OP_DIVU:  return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default:  return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Monitor: every completion must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("spurious_done", 64'(done), 64'd0);
            end else begin
                monE = sb.pop_front();
                check("rw", 64'(RW), 64'(monE.rw));
                check("da", 64'(DA), 64'(monE.da));
                check("writeData", 64'(writeData), 64'(monE.data));
                check("latency", 64'(cyc), 64'(monE.doneCyc));
            end
        end else begin
            check("rw_without_done", 64'(RW), 64'd0);
        end
        if (sb.size() > 0 && reset === 1'b1) begin
            if (cyc >= sb[0].startCyc && cyc <= sb[0].doneCyc)
                check("busy", 64'(busy), 64'd1);
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input bit push);
        exp_t e;
        @(negedge clk);
        start = 1'b1;
        op    = o;
        opA   = a;
        opB   = b;
        dest  = d;
        if (push) begin
            e.rw       = (d != 5'd0);
            e.da       = d;
            e.data     = model(o, a, b);
            e.startCyc = cyc + 1;
            e.doneCyc  = e.startCyc + ((o[1] && b == 32'd0) ? 1 : 33);
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            check("timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 255));
            default: return 32'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        opA   = '0;
        opB   = '0;
        dest  = '0;
        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_rw", 64'(RW), 64'd0);
        check("reset_da", 64'(DA), 64'd0);
        check("reset_wdata", 64'(writeData), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        issue(OP_MUL, 32'h0001_0000, 32'h0001_0000, 5'd5, 1'b1);   waitDone();
        issue(OP_MULHU, 32'h0001_0000, 32'h0001_0000, 5'd5, 1'b1); waitDone();
        issue(OP_DIVU, 32'd100, 32'd7, 5'd10, 1'b1);                waitDone();
        issue(OP_REMU, 32'd100, 32'd7, 5'd10, 1'b1);                waitDone();
        issue(OP_DIVU, 32'hA5A5_A5A5, 32'd0, 5'd3, 1'b1);           waitDone();
        issue(OP_REMU, 32'hA5A5_A5A5, 32'd0, 5'd3, 1'b1);           waitDone();
        issue(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 1'b1);    waitDone();
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 1'b1);  waitDone();

        // A second start while busy must be ignored.
        issue(OP_DIVU, 32'd1000, 32'd3, 5'd9, 1'b1);
        repeat (8) @(negedge clk);
        start = 1'b1;
        op    = OP_MUL;
        opA   = 32'd5;
        opB   = 32'd6;
        dest  = 5'd2;
        @(negedge clk);
        start = 1'b0;
        waitDone();

        // Flush mid-CALC: no write-back, busy drops next cycle.
        issue(OP_MUL, 32'd7, 32'd9, 5'd4, 1'b0);
        repeat (18) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_calc_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);

        // Flush in WRITE (divide-by-zero goes straight there).
        issue(OP_DIVU, 32'd5, 32'd0, 5'd6, 1'b0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_write_done", 64'(done), 64'd0);
        check("flush_write_busy", 64'(busy), 64'd0);

        // Flush together with start in IDLE: start is not accepted.
        @(negedge clk);
        start = 1'b1;
        flush = 1'b1;
        op    = OP_MUL;
        opA   = 32'd2;
        opB   = 32'd2;
        dest  = 5'd8;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        check("flush_idle_busy", 64'(busy), 64'd0);
        repeat (40) @(negedge clk);

        // Asynchronous reset mid-CALC.
        issue(OP_MUL, 32'd11, 32'd13, 5'd12, 1'b0);
        repeat (10) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("areset_busy", 64'(busy), 64'd0);
        check("areset_rw", 64'(RW), 64'd0);
        check("areset_done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        issue(OP_MUL, 32'd3, 32'd4, 5'd1, 1'b1);
        waitDone();

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = pick();
            b = pick();
            issue(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)), 1'b1);
            waitDone();
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
